// File: rtl/mel_band_accumulator.sv
// Sums consecutive FFT-bin powers into N_BANDS rectangular bands with programmable
// inclusive end-bin edges; emits one saturated energy per completed band.
module mel_band_accumulator #(
    parameter int I_BW    = 32,
    parameter int O_BW    = 32,
    parameter int N_BINS  = 256,
    parameter int N_BANDS = 32,
    parameter int EDGE_BW = 8,
    parameter logic [N_BANDS*EDGE_BW-1:0] EDGES =
        256'hFFF7EFE7_DFD7CFC7_BFB7AFA7_9F978F87_7F776F67_5F574F47_3F372F27_1F170F07
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            last_o,
    output logic            err_o
);

    // state  | meaning
    // IDLE   | waiting for bin 0 of a frame (bin_cnt == 0)
    // ACCUM  | inside a frame, summing bins into the current band

    localparam int ACC_BW  = I_BW + EDGE_BW;
    localparam int BIDX_BW = $clog2(N_BANDS + 1);

    localparam logic [EDGE_BW-1:0] LAST_BIN  = EDGE_BW'(N_BINS - 1);
    localparam logic [BIDX_BW-1:0] LAST_BAND = BIDX_BW'(N_BANDS - 1);
    localparam logic [BIDX_BW-1:0] END_BAND  = BIDX_BW'(N_BANDS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [EDGE_BW-1:0]  bin_cnt_q, bin_cnt_d;
    logic [BIDX_BW-1:0]  band_idx_q, band_idx_d;
    logic [ACC_BW-1:0]   acc_q, acc_d;
    logic [O_BW-1:0]     data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic                accept;
    logic                band_live;
    logic                band_end;
    logic                at_last_bin;
    logic                frame_end;
    logic                early_last;
    logic                missing_last;
    logic [EDGE_BW-1:0]  edge_sel;
    logic [ACC_BW-1:0]   sum;
    logic [O_BW-1:0]     sum_sat;

    assign accept       = valid_i & en_i;
    assign band_live    = band_idx_q < END_BAND;
    assign at_last_bin  = bin_cnt_q == LAST_BIN;
    assign band_end     = accept & band_live & (bin_cnt_q == edge_sel);
    assign frame_end    = accept & (last_i | at_last_bin);
    assign early_last   = accept & last_i & ~at_last_bin;
    assign missing_last = accept & ~last_i & at_last_bin;
    assign sum          = acc_q + ACC_BW'(data_i);
    assign sum_sat      = (|sum[ACC_BW-1:O_BW]) ? {O_BW{1'b1}} : sum[O_BW-1:0];

    always_comb begin
        edge_sel = '0;
        for (int b = 0; b < N_BANDS; b++) begin
            if (band_idx_q == BIDX_BW'(b)) begin
                edge_sel = EDGES[b*EDGE_BW +: EDGE_BW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            bin_cnt_q  <= '0;
            band_idx_q <= '0;
            acc_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_cnt_q  <= bin_cnt_d;
            band_idx_q <= band_idx_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !frame_end) state_d = S_ACCUM;
            S_ACCUM: if (frame_end)            state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bin_cnt_d  = bin_cnt_q;
        band_idx_d = band_idx_q;
        acc_d      = acc_q;
        if (accept) begin
            bin_cnt_d = (state_q == S_IDLE) ? EDGE_BW'(1) : bin_cnt_q + EDGE_BW'(1);
            if (band_end) begin
                acc_d      = '0;
                band_idx_d = band_idx_q + BIDX_BW'(1);
            end else if (band_live) begin
                acc_d = sum;
            end
        end
        // Any frame end (normal, early or missing last) drops the partial band.
        if (frame_end) begin
            bin_cnt_d  = '0;
            band_idx_d = '0;
            acc_d      = '0;
        end
    end

    always_comb begin
        valid_d = band_end;
        data_d  = band_end ? sum_sat : '0;
        last_d  = band_end & (band_idx_q == LAST_BAND) & ~early_last;
        err_d   = early_last | missing_last;
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

`ifndef SYNTHESIS
    function automatic bit edges_valid();
        for (int b = 0; b < N_BANDS; b++) begin
            if (int'(EDGES[b*EDGE_BW +: EDGE_BW]) > N_BINS - 1) return 1'b0;
            if (b > 0) begin
                if (EDGES[b*EDGE_BW +: EDGE_BW] <= EDGES[(b-1)*EDGE_BW +: EDGE_BW]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    localparam bit EDGES_OK = edges_valid();

    always @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (EDGES_OK)
            else $error("EDGES not strictly increasing or beyond last bin");
        end
    end
`endif

endmodule

// File: tb/tb_mel_band_accumulator.sv
// Directed bench for mel_band_accumulator with default edges (8 bins per band).
module tb_mel_band_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic [31:0] data_o;
    logic        valid_o;
    logic        last_o;
    logic        err_o;

    mel_band_accumulator dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .data_i  (data),
        .valid_i (valid),
        .last_i  (last),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_data[$];
    bit          log_last[$];
    int          log_cyc[$];
    int          err_log[$];
    int          beat_cyc[$];

    always @(negedge clk) begin
        if (valid_o) begin
            log_data.push_back(data_o);
            log_last.push_back(last_o);
            log_cyc.push_back(cyc);
        end
        if (err_o) err_log.push_back(cyc);
    end

    task automatic drive(input logic v, input logic e, input logic [31:0] d, input logic l);
        @(negedge clk);
        valid = v;
        en    = e;
        data  = d;
        last  = l;
        if (v && e) beat_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 32'd0, 1'b0);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        err_log.delete();
        beat_cyc.delete();
    endtask

    function automatic logic [31:0] pat(input int p, input int k);
        case (p)
            0:       return 32'd1;
            1:       return 32'(k);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic send_frame(input int p, input int n, input int last_at);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b1, pat(p, k), k == last_at);
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0; en = 1'b0; data = '0; last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_o !== 32'd0 || valid_o !== 1'b0 || last_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: data %0h valid %0b last %0b err %0b, required all 0",
                     data_o, valid_o, last_o, err_o);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_ones();
        clear_log();
        send_frame(0, 256, 255);
        checks++;
        if (log_data.size() != 32 || err_log.size() != 0) begin
            errors++;
            $display("FAIL ones count: outputs %0d errs %0d, required 32 0", log_data.size(), err_log.size());
        end
        for (int b = 0; b < 32 && b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'd8 || log_last[b] !== (b == 31) || log_cyc[b] !== beat_cyc[8*b+7] + 1) begin
                errors++;
                $display("FAIL ones band %0d: data %0d last %0b cyc %0d, required 8 %0b %0d",
                         b, log_data[b], log_last[b], log_cyc[b], b == 31, beat_cyc[8*b+7] + 1);
            end
        end
    endtask

    task automatic test_ramp();
        clear_log();
        send_frame(1, 256, 255);
        checks++;
        if (log_data.size() != 32 || err_log.size() != 0) begin
            errors++;
            $display("FAIL ramp count: outputs %0d errs %0d, required 32 0", log_data.size(), err_log.size());
        end
        for (int b = 0; b < 32 && b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'(64*b + 28) || log_last[b] !== (b == 31) ||
                log_cyc[b] !== beat_cyc[8*b+7] + 1) begin
                errors++;
                $display("FAIL ramp band %0d: data %0d last %0b cyc %0d, required %0d %0b %0d",
                         b, log_data[b], log_last[b], log_cyc[b], 64*b + 28, b == 31, beat_cyc[8*b+7] + 1);
            end
        end
    endtask

    task automatic test_saturate();
        clear_log();
        send_frame(2, 256, 255);
        checks++;
        if (log_data.size() != 32) begin
            errors++;
            $display("FAIL sat count: outputs %0d, required 32", log_data.size());
        end
        for (int b = 0; b < 32 && b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL sat band %0d: data %0h, required ffffffff", b, log_data[b]);
            end
        end
    endtask

    task automatic test_early_last();
        clear_log();
        send_frame(0, 101, 100);
        checks++;
        if (log_data.size() != 12) begin
            errors++;
            $display("FAIL early count: outputs %0d, required 12", log_data.size());
        end
        for (int b = 0; b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'd8 || log_last[b] !== 1'b0) begin
                errors++;
                $display("FAIL early band %0d: data %0d last %0b, required 8 0", b, log_data[b], log_last[b]);
            end
        end
        checks++;
        if (err_log.size() != 1 || err_log[0] !== beat_cyc[100] + 1) begin
            errors++;
            $display("FAIL early err: pulses %0d first cyc %0d, required 1 at %0d",
                     err_log.size(), (err_log.size() > 0) ? err_log[0] : -1, beat_cyc[100] + 1);
        end
        clear_log();
        send_frame(1, 256, 255);
        checks++;
        if (log_data.size() != 32 || log_data[0] !== 32'd28 || log_data[31] !== 32'd2012 ||
            log_last[31] !== 1'b1 || err_log.size() != 0) begin
            errors++;
            $display("FAIL early recover: outputs %0d band0 %0d band31 %0d errs %0d, required 32 28 2012 0",
                     log_data.size(), log_data[0], log_data[31], err_log.size());
        end
    endtask

    task automatic test_missing_last();
        clear_log();
        send_frame(0, 256, -1);
        checks++;
        if (log_data.size() != 32) begin
            errors++;
            $display("FAIL nolast count: outputs %0d, required 32", log_data.size());
        end
        for (int b = 0; b < 32 && b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'd8 || log_last[b] !== (b == 31)) begin
                errors++;
                $display("FAIL nolast band %0d: data %0d last %0b, required 8 %0b",
                         b, log_data[b], log_last[b], b == 31);
            end
        end
        checks++;
        if (err_log.size() != 1 || err_log[0] !== beat_cyc[255] + 1) begin
            errors++;
            $display("FAIL nolast err: pulses %0d first cyc %0d, required 1 at %0d",
                     err_log.size(), (err_log.size() > 0) ? err_log[0] : -1, beat_cyc[255] + 1);
        end
        clear_log();
        send_frame(0, 256, 255);
        checks++;
        if (log_data.size() != 32 || log_data[0] !== 32'd8 || log_data[31] !== 32'd8 ||
            log_last[31] !== 1'b1 || err_log.size() != 0) begin
            errors++;
            $display("FAIL nolast recover: outputs %0d band0 %0d band31 %0d errs %0d, required 32 8 8 0",
                     log_data.size(), log_data[0], log_data[31], err_log.size());
        end
    endtask

    task automatic test_gaps();
        clear_log();
        for (int k = 0; k < 256; k++) begin
            drive(1'b0, 1'b1, 32'd1000, 1'b0);
            if (k == 20) repeat (5) drive(1'b1, 1'b0, 32'd5000, 1'b0);
            drive(1'b1, 1'b1, 32'd1, k == 255);
        end
        idle(3);
        checks++;
        if (log_data.size() != 32 || err_log.size() != 0) begin
            errors++;
            $display("FAIL gaps count: outputs %0d errs %0d, required 32 0", log_data.size(), err_log.size());
        end
        for (int b = 0; b < 32 && b < log_data.size(); b++) begin
            checks++;
            if (log_data[b] !== 32'd8 || log_last[b] !== (b == 31) || log_cyc[b] !== beat_cyc[8*b+7] + 1) begin
                errors++;
                $display("FAIL gaps band %0d: data %0d last %0b cyc %0d, required 8 %0b %0d",
                         b, log_data[b], log_last[b], log_cyc[b], b == 31, beat_cyc[8*b+7] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        for (int k = 0; k < 48; k++) drive(1'b1, 1'b1, 32'd1, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'd8) begin
            errors++;
            $display("FAIL rst pre: valid %0b data %0d, required 1 8", valid_o, data_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (data_o !== 32'd0 || valid_o !== 1'b0 || last_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst async: data %0h valid %0b last %0b err %0b, required all 0",
                     data_o, valid_o, last_o, err_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        clear_log();
        send_frame(1, 256, 255);
        checks++;
        if (log_data.size() != 32 || log_data[0] !== 32'd28 || log_data[31] !== 32'd2012 ||
            log_last[31] !== 1'b1 || err_log.size() != 0) begin
            errors++;
            $display("FAIL rst recover: outputs %0d band0 %0d band31 %0d errs %0d, required 32 28 2012 0",
                     log_data.size(), log_data[0], log_data[31], err_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_saturate();
        test_early_last();
        test_missing_last();
        test_gaps();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
